// File: rtl/soc_noc_echo_responder.sv
// -----------------------------------------------------------------------------
// soc_noc_echo_responder
//
// Simulation-side NoC endpoint for single-tile benches. It collects one whole
// packet from the tile, then plays it back with the header's destination and
// source fields swapped. The packet reaches the tile as if a remote tile had
// answered it. Receive and transmit never overlap: the responder either
// accepts input (RX/DRAIN) or drives output (TX).
//
// Ports
//   clk            single clock
//   rst            synchronous, active-high reset
//   noc_in_flit    flit from the tile (tile's noc_out_flit)
//   noc_in_last    final flit of the incoming packet
//   noc_in_valid   incoming flit valid
//   noc_in_ready   responder accepts an incoming flit (RX/DRAIN only)
//   noc_out_flit   flit to the tile (tile's noc_in_flit)
//   noc_out_last   final flit of the echoed packet
//   noc_out_valid  echoed flit valid (TX only)
//   noc_out_ready  tile accepts an echoed flit
//   pkt_count      packets fully echoed, wraps at 2^16
//   trunc_count    incoming packets longer than the buffer, wraps at 2^16
//
// Packets longer than MAX_PKT_LEN are truncated. The first MAX_PKT_LEN flits
// are kept and the rest are accepted and dropped up to the tail flit. The
// truncated packet is then echoed.
// -----------------------------------------------------------------------------
module soc_noc_echo_responder #(
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8,
  parameter int DEST_MSB    = 31,
  parameter int SRC_MSB     = 23,
  parameter int ID_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                  noc_in_last,
  input  logic                  noc_in_valid,
  output logic                  noc_in_ready,
  output logic [FLIT_WIDTH-1:0] noc_out_flit,
  output logic                  noc_out_last,
  output logic                  noc_out_valid,
  input  logic                  noc_out_ready,
  output logic [15:0]           pkt_count,
  output logic [15:0]           trunc_count
);

  // Pointer width covers indices 0..MAX_PKT_LEN-1. Length width also covers
  // MAX_PKT_LEN itself.
  localparam int PTR_W = (MAX_PKT_LEN > 2) ? $clog2(MAX_PKT_LEN) : 1;
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  // RX and TX are the two architectural states. DRAIN is the part of RX that
  // follows a truncation, where incoming flits are no longer stored.
  localparam logic [1:0] ST_RX    = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TX    = 2'd2;

  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(MAX_PKT_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_PKT_LEN);

  logic [1:0]       state_q,       state_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [LEN_W-1:0] len_q,         len_d;
  logic [15:0]      pkt_count_q,   pkt_count_d;
  logic [15:0]      trunc_count_q, trunc_count_d;

  logic                  mem_we;
  logic                  in_fire;
  logic                  out_fire;
  logic                  tx_tail;
  logic [FLIT_WIDTH-1:0] hdr_word;
  logic [FLIT_WIDTH-1:0] tx_word;

  // Packet buffer. It has no reset: contents are only read below len_q, and
  // those entries are always rewritten before they are read.
  logic [FLIT_WIDTH-1:0] pkt_mem [MAX_PKT_LEN];

  // ---------------------------------------------------------------------------
  // Handshake signals, decoded from the state register only
  // ---------------------------------------------------------------------------
  // noc_in_ready and noc_out_valid depend only on state_q. There is no
  // combinational path from noc_out_ready into the input side.
  assign noc_in_ready  = (state_q != ST_TX);
  assign noc_out_valid = (state_q == ST_TX);

  assign in_fire  = noc_in_valid && noc_in_ready;
  assign out_fire = noc_out_valid && noc_out_ready;

  // Current flit is the last one of the echo.
  assign tx_tail = (LEN_W'(rd_ptr_q) == (len_q - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    len_d         = len_q;
    pkt_count_d   = pkt_count_q;
    trunc_count_d = trunc_count_q;
    mem_we        = 1'b0;

    case (state_q)
      ST_RX: begin
        if (in_fire) begin
          mem_we = 1'b1;
          if (noc_in_last) begin
            len_d   = LEN_W'(wr_ptr_q) + LEN_W'(1);
            state_d = ST_TX;
          end else if (wr_ptr_q == PTR_TOP) begin
            // Buffer full with the packet still open. Keep what is stored
            // and drop the rest.
            len_d   = LEN_FULL;
            state_d = ST_DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Flits are accepted but not stored. The tail flit ends the packet.
        if (in_fire && noc_in_last) begin
          trunc_count_d = trunc_count_q + 16'd1;
          state_d       = ST_TX;
        end
      end

      ST_TX: begin
        if (out_fire) begin
          if (tx_tail) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = ST_RX;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end

      default: begin
        // Unused encoding: go back to a clean receive state.
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        state_d  = ST_RX;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output flit: buffer entry at rd_ptr, with the header fields swapped
  // ---------------------------------------------------------------------------
  assign hdr_word = pkt_mem[0];

  always_comb begin
    tx_word = pkt_mem[rd_ptr_q];
    if (rd_ptr_q == '0) begin
      tx_word[DEST_MSB -: ID_WIDTH] = hdr_word[SRC_MSB -: ID_WIDTH];
      tx_word[SRC_MSB -: ID_WIDTH]  = hdr_word[DEST_MSB -: ID_WIDTH];
    end
  end

  // Outside TX the output bus is forced to zero. Stale buffer contents never
  // appear on it, and it reads 0 out of reset. In TX the buffer and rd_ptr
  // are frozen during a stall, so flit and last hold stable.
  assign noc_out_flit = (state_q == ST_TX) ? tx_word : '0;
  assign noc_out_last = (state_q == ST_TX) && tx_tail;

  assign pkt_count   = pkt_count_q;
  assign trunc_count = trunc_count_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RX;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      pkt_count_q   <= '0;
      trunc_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      len_q         <= len_d;
      pkt_count_q   <= pkt_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pkt_mem[wr_ptr_q] <= noc_in_flit;
    end
  end

endmodule

// File: tb/tb_soc_noc_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_soc_noc_echo_responder
//
// Directed bench for the echo responder. Each scenario task builds a packet,
// sends it through the input port, and collects the echo with a chosen
// noc_out_ready pattern. It then compares the results against hand-computed
// values.
// Inputs change 1 time unit after the rising edge. Outputs are read at the
// same point, so every value seen belongs to the current cycle.
// -----------------------------------------------------------------------------
module tb_soc_noc_echo_responder;

  logic        clk;
  logic        rst;
  logic [31:0] noc_in_flit;
  logic        noc_in_last;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready;
  logic [15:0] pkt_count;
  logic [15:0] trunc_count;

  int total;
  int bad;

  logic [31:0] in_vec  [16];
  logic [31:0] exp_vec [16];
  logic [31:0] got_flit[32];
  logic        got_last[32];
  int          n_got;
  int          stab_viol;
  int          inrdy_viol;
  int          refused;
  int          early_valid;
  logic        first_valid;
  logic        post_in_ready;
  logic        post_out_valid;
  logic        timed_out;

  soc_noc_echo_responder dut (
    .clk          (clk),
    .rst          (rst),
    .noc_in_flit  (noc_in_flit),
    .noc_in_last  (noc_in_last),
    .noc_in_valid (noc_in_valid),
    .noc_in_ready (noc_in_ready),
    .noc_out_flit (noc_out_flit),
    .noc_out_last (noc_out_last),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .pkt_count    (pkt_count),
    .trunc_count  (trunc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    noc_in_valid  = 1'b0;
    noc_in_last   = 1'b0;
    noc_in_flit   = '0;
    noc_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives in_vec[0..n-1] as one packet. If gaps is set, an idle cycle goes
  // between flits. Counts cycles where the responder refused a flit and
  // cycles where it raised output valid during receive.
  task automatic send_pkt(input int n, input int gaps);
    refused     = 0;
    early_valid = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps != 0 && i > 0) begin
        noc_in_valid = 1'b0;
        noc_in_last  = 1'b0;
        if (noc_out_valid) early_valid++;
        tick();
      end
      noc_in_valid = 1'b1;
      noc_in_flit  = in_vec[i];
      noc_in_last  = (i == n - 1);
      if (!noc_in_ready) refused++;
      if (noc_out_valid) early_valid++;
      tick();
    end
    noc_in_valid = 1'b0;
    noc_in_last  = 1'b0;
    noc_in_flit  = '0;
  endtask

  // Collects one echoed packet. mode 0 holds ready high. mode 1 drives
  // ready 1,0,0,1,0,0,... Also counts stall-stability violations and
  // cycles where input and output were both open.
  task automatic collect_out(input int mode);
    logic        r;
    logic        prev_stall;
    logic [31:0] prev_flit;
    logic        prev_last;
    logic        done;
    n_got       = 0;
    stab_viol   = 0;
    inrdy_viol  = 0;
    first_valid = noc_out_valid;
    prev_stall  = 1'b0;
    prev_flit   = '0;
    prev_last   = 1'b0;
    done        = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      r = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      noc_out_ready = r;
      if (noc_out_valid) begin
        if (noc_in_ready) inrdy_viol++;
        if (prev_stall && (noc_out_flit !== prev_flit || noc_out_last !== prev_last))
          stab_viol++;
        if (r) begin
          if (n_got < 32) begin
            got_flit[n_got] = noc_out_flit;
            got_last[n_got] = noc_out_last;
          end
          n_got++;
          if (noc_out_last) done = 1'b1;
        end
        prev_stall = !r;
        prev_flit  = noc_out_flit;
        prev_last  = noc_out_last;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
    end
    timed_out      = !done;
    post_in_ready  = noc_in_ready;
    post_out_valid = noc_out_valid;
    noc_out_ready  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    total++; if (noc_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", noc_in_ready); end
    total++; if (noc_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", noc_out_valid); end
    total++; if (noc_out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b exp=0", noc_out_last); end
    total++; if (noc_out_flit !== 32'h0) begin bad++; $display("FAIL reset_out_flit got=%08h exp=00000000", noc_out_flit); end
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    total++; if (trunc_count !== 16'd0) begin bad++; $display("FAIL reset_trunc_count got=%0d exp=0", trunc_count); end
    $display("test_reset: in_ready=%0b out_valid=%0b", noc_in_ready, noc_out_valid);
  endtask

  task automatic test_basic_3flit();
    do_reset();
    in_vec[0] = 32'h0808_0000; in_vec[1] = 32'h0000_000A; in_vec[2] = 32'h0000_000B;
    exp_vec[0] = 32'h0808_0000; exp_vec[1] = 32'h0000_000A; exp_vec[2] = 32'h0000_000B;
    send_pkt(3, 0);
    collect_out(0);
    total++; if (refused !== 0) begin bad++; $display("FAIL basic_refused got=%0d exp=0", refused); end
    total++; if (early_valid !== 0) begin bad++; $display("FAIL basic_early_valid got=%0d exp=0", early_valid); end
    total++; if (first_valid !== 1'b1) begin bad++; $display("FAIL basic_latency valid_next_cycle got=%0b exp=1", first_valid); end
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0b exp=0", timed_out); end
    total++; if (n_got !== 3) begin bad++; $display("FAIL basic_len got=%0d exp=3", n_got); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= n_got || got_flit[i] !== exp_vec[i] || got_last[i] !== (i == 2)) begin
        bad++;
        $display("FAIL basic_flit%0d got=%08h/%0b exp=%08h/%0b", i, got_flit[i], got_last[i], exp_vec[i], (i == 2));
      end
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL basic_pkt_count got=%0d exp=1", pkt_count); end
    total++; if (post_in_ready !== 1'b1 || post_out_valid !== 1'b0) begin bad++; $display("FAIL basic_return_rx got=%0b/%0b exp=1/0", post_in_ready, post_out_valid); end
    $display("test_basic_3flit: echoed=%0d pkt_count=%0d", n_got, pkt_count);
  endtask

  task automatic test_header_swap();
    do_reset();
    in_vec[0] = 32'h1020_0001;
    send_pkt(1, 0);
    collect_out(0);
    total++; if (first_valid !== 1'b1) begin bad++; $display("FAIL swap_latency got=%0b exp=1", first_valid); end
    total++; if (n_got !== 1) begin bad++; $display("FAIL swap_len got=%0d exp=1", n_got); end
    total++;
    if (n_got < 1 || got_flit[0] !== 32'h2010_0001 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL swap_flit got=%08h/%0b exp=20100001/1", got_flit[0], got_last[0]);
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL swap_pkt_count got=%0d exp=1", pkt_count); end
    $display("test_header_swap: out=%08h", got_flit[0]);
  endtask

  task automatic test_backpressure();
    do_reset();
    in_vec[0] = 32'h0810_0003; in_vec[1] = 32'h0000_0011;
    in_vec[2] = 32'h0000_0022; in_vec[3] = 32'h0000_0033;
    exp_vec[0] = 32'h1008_0003; exp_vec[1] = 32'h0000_0011;
    exp_vec[2] = 32'h0000_0022; exp_vec[3] = 32'h0000_0033;
    send_pkt(4, 1);
    collect_out(1);
    total++; if (refused !== 0 || early_valid !== 0) begin bad++; $display("FAIL bp_rx_gaps refused=%0d early=%0d exp=0/0", refused, early_valid); end
    total++; if (stab_viol !== 0) begin bad++; $display("FAIL bp_stability got=%0d exp=0", stab_viol); end
    total++; if (inrdy_viol !== 0) begin bad++; $display("FAIL bp_in_ready_during_tx got=%0d exp=0", inrdy_viol); end
    total++; if (n_got !== 4) begin bad++; $display("FAIL bp_len got=%0d exp=4", n_got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= n_got || got_flit[i] !== exp_vec[i] || got_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL bp_flit%0d got=%08h/%0b exp=%08h/%0b", i, got_flit[i], got_last[i], exp_vec[i], (i == 3));
      end
    end
    total++; if (post_in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%0b exp=1", post_in_ready); end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL bp_pkt_count got=%0d exp=1", pkt_count); end
    $display("test_backpressure: echoed=%0d stalls_ok=%0b", n_got, (stab_viol == 0));
  endtask

  task automatic test_full_length();
    do_reset();
    in_vec[0]  = 32'h2008_0000;
    exp_vec[0] = 32'h0820_0000;
    for (int i = 1; i < 8; i++) begin
      in_vec[i]  = 32'h0000_0100 + i;
      exp_vec[i] = 32'h0000_0100 + i;
    end
    send_pkt(8, 0);
    collect_out(0);
    total++; if (n_got !== 8) begin bad++; $display("FAIL full_len got=%0d exp=8", n_got); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= n_got || got_flit[i] !== exp_vec[i] || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL full_flit%0d got=%08h/%0b exp=%08h/%0b", i, got_flit[i], got_last[i], exp_vec[i], (i == 7));
      end
    end
    total++; if (trunc_count !== 16'd0) begin bad++; $display("FAIL full_trunc_count got=%0d exp=0", trunc_count); end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL full_pkt_count got=%0d exp=1", pkt_count); end
    $display("test_full_length: echoed=%0d trunc=%0d", n_got, trunc_count);
  endtask

  task automatic test_truncation();
    do_reset();
    in_vec[0]  = 32'h1818_0000;
    exp_vec[0] = 32'h1818_0000;
    for (int i = 1; i < 11; i++) begin
      in_vec[i]  = i;
      exp_vec[i] = i;
    end
    send_pkt(11, 0);
    collect_out(0);
    total++; if (refused !== 0) begin bad++; $display("FAIL trunc_accept refused=%0d exp=0", refused); end
    total++; if (first_valid !== 1'b1) begin bad++; $display("FAIL trunc_latency got=%0b exp=1", first_valid); end
    total++; if (n_got !== 8) begin bad++; $display("FAIL trunc_len got=%0d exp=8", n_got); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= n_got || got_flit[i] !== exp_vec[i] || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL trunc_flit%0d got=%08h/%0b exp=%08h/%0b", i, got_flit[i], got_last[i], exp_vec[i], (i == 7));
      end
    end
    total++; if (trunc_count !== 16'd1) begin bad++; $display("FAIL trunc_count got=%0d exp=1", trunc_count); end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL trunc_pkt_count got=%0d exp=1", pkt_count); end
    $display("test_truncation: echoed=%0d trunc=%0d", n_got, trunc_count);
  endtask

  task automatic test_reset_mid_tx();
    do_reset();
    in_vec[0] = 32'h0808_0009;
    send_pkt(1, 0);
    collect_out(0);
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=1", pkt_count); end
    for (int i = 0; i < 5; i++) in_vec[i] = 32'h0000_0500 + i;
    send_pkt(5, 0);
    noc_out_ready = 1'b1;
    tick();
    tick();
    total++; if (noc_out_valid !== 1'b1) begin bad++; $display("FAIL midrst_in_tx got=%0b exp=1", noc_out_valid); end
    rst           = 1'b1;
    noc_out_ready = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (noc_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b exp=0", noc_out_valid); end
    total++; if (noc_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=1", noc_in_ready); end
    total++; if (pkt_count !== 16'd0 || trunc_count !== 16'd0) begin bad++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", pkt_count, trunc_count); end
    in_vec[0] = 32'h1830_00FF; in_vec[1] = 32'hDEAD_BEEF;
    send_pkt(2, 0);
    collect_out(0);
    total++; if (n_got !== 2) begin bad++; $display("FAIL midrst_fresh_len got=%0d exp=2", n_got); end
    total++;
    if (n_got < 2 || got_flit[0] !== 32'h3018_00FF || got_last[0] !== 1'b0 ||
        got_flit[1] !== 32'hDEAD_BEEF || got_last[1] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_fresh_flits got=%08h/%0b %08h/%0b exp=301800ff/0 deadbeef/1",
               got_flit[0], got_last[0], got_flit[1], got_last[1]);
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL midrst_fresh_count got=%0d exp=1", pkt_count); end
    $display("test_reset_mid_tx: fresh echoed=%0d pkt_count=%0d", n_got, pkt_count);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    // Stand-in for 65535 earlier echoes.
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    release dut.pkt_count_q;
    total++; if (pkt_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%04h exp=ffff", pkt_count); end
    in_vec[0] = 32'h0808_0007;
    send_pkt(1, 0);
    collect_out(0);
    total++;
    if (n_got !== 1 || got_flit[0] !== 32'h0808_0007 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_flit got=%0d:%08h/%0b exp=1:08080007/1", n_got, got_flit[0], got_last[0]);
    end
    total++; if (pkt_count !== 16'h0000) begin bad++; $display("FAIL wrap_pkt_count got=%04h exp=0000", pkt_count); end
    $display("test_counter_wrap: pkt_count=%04h", pkt_count);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    noc_in_flit   = '0;
    noc_in_last   = 1'b0;
    noc_in_valid  = 1'b0;
    noc_out_ready = 1'b0;
    test_reset();
    test_basic_3flit();
    test_header_swap();
    test_backpressure();
    test_full_length();
    test_truncation();
    test_reset_mid_tx();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
